// File: rtl/ld_nn_ixiy_store_seq_pkg.sv
// ---------------------------------------------------------------------------
// ld_nn_ixiy_store_seq_pkg
// Purpose : shared definitions for the LD (nn),IX / LD (nn),IY store
//           sequencer: step encoding seen by the shared step decoders,
//           opcode constants of the instruction it executes, and the
//           default bus widths.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package ld_nn_ixiy_store_seq_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Prefix / opcode bytes that route execution to this sequencer.
  localparam logic [7:0] PFX_IX      = 8'hDD;
  localparam logic [7:0] PFX_IY      = 8'hFD;
  localparam logic [7:0] OP_LD_NN_RR = 8'h22;

  // State values double as the xpt step number, so keep them explicit.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_LO = 4'd1,
    ST_RD_HI = 4'd2,
    ST_WR_LO = 4'd3,
    ST_WR_HI = 4'd4,
    ST_FIN   = 4'd5
  } state_t;

endpackage

// File: rtl/ld_nn_ixiy_store_seq_inc16.sv
// ---------------------------------------------------------------------------
// ld_nn_ixiy_store_seq_inc16
// Purpose : W-bit increment with natural wrap (0xFFFF + 1 = 0x0000).
//           Produces nn+1 for the high-byte write address and for the
//           optional memptr load.
// Ports   : i_a  in  W  operand
//           o_y  out W  i_a + 1 modulo 2^W
// ---------------------------------------------------------------------------
module ld_nn_ixiy_store_seq_inc16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  // Carry out of the MSB is dropped on purpose: the address space wraps.
  assign o_y = i_a + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/ld_nn_ixiy_store_seq.sv
// ---------------------------------------------------------------------------
// ld_nn_ixiy_store_seq
// Purpose : execution sequencer for LD (nn),IX / LD (nn),IY (DD/FD 22).
//           After a start pulse from the opcode decoder it reads the nn
//           operand at pc, pc+1 (low byte first), writes src[7:0] to nn and
//           src[15:8] to nn+1, then pulses set_cm1/reset_itable to hand
//           control back to the M1 fetch.
// Build option : define LD_NN_IXIY_MEMPTR_EN to add the memptr output (the
//           Z80 WZ side effect, loaded with nn+1 when the high byte write
//           completes). Without it the port and its register do not exist.
// Parameters : ADDR_W (16) address width, DATA_W (8) data width; the block
//           only makes sense with ADDR_W = 2*DATA_W = 16.
// Ports   : CLK          in   clock, rising edge
//           notRESET     in   asynchronous active-low reset
//           start        in   decoder pulse, honoured only in IDLE
//           sel_iy       in   sampled with start: 0 = IX, 1 = IY
//           pc           in   operand fetch address
//           ix, iy       in   index register values
//           mem_req      out  transfer request
//           mem_we       out  1 = write, 0 = read
//           mem_addr     out  transfer address
//           mem_wdata    out  write data
//           mem_rdata    in   read data, valid with mem_ack
//           mem_ack      in   transfer complete
//           pc_inc       out  PC+1 request, on each read ack
//           busy         out  high outside IDLE
//           xpt          out  current step number (state encoding)
//           set_cm1      out  begin next M1 (one cycle, in FIN)
//           reset_itable out  coincident with set_cm1
//           memptr       out  (option) nn+1 after the store
// ---------------------------------------------------------------------------
module ld_nn_ixiy_store_seq
  import ld_nn_ixiy_store_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              notRESET,
  input  logic              start,
  input  logic              sel_iy,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ix,
  input  logic [ADDR_W-1:0] iy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pc_inc,
  output logic              busy,
  output logic [3:0]        xpt,
  output logic              set_cm1,
  output logic              reset_itable
`ifdef LD_NN_IXIY_MEMPTR_EN
  ,
  output logic [ADDR_W-1:0] memptr
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_nn;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] w_nn_inc;

  ld_nn_ixiy_store_seq_inc16 #(
    .W (ADDR_W)
  ) u_inc (
    .i_a (r_nn),
    .o_y (w_nn_inc)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. In every transfer state mem_req is high, so mem_ack
  // alone marks completion there; an ack in IDLE or FIN is never looked at.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)   w_state_next = ST_RD_LO;
      ST_RD_LO: if (mem_ack) w_state_next = ST_RD_HI;
      ST_RD_HI: if (mem_ack) w_state_next = ST_WR_LO;
      ST_WR_LO: if (mem_ack) w_state_next = ST_WR_HI;
      ST_WR_HI: if (mem_ack) w_state_next = ST_FIN;
      ST_FIN:                w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything except pc_inc depends only on the state, so the
  // memory port stays frozen while waiting for ack and mem_req stays high
  // across the RD_LO..WR_HI chain.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pc_inc       = 1'b0;
    busy         = (r_state != ST_IDLE);
    xpt          = 4'(r_state);
    set_cm1      = 1'b0;
    reset_itable = 1'b0;
    case (r_state)
      ST_RD_LO, ST_RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        pc_inc   = mem_ack;
      end
      ST_WR_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_nn;
        mem_wdata = r_src[DATA_W-1:0];
      end
      ST_WR_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_nn_inc;
        mem_wdata = r_src[ADDR_W-1:DATA_W];
      end
      ST_FIN: begin
        set_cm1      = 1'b1;
        reset_itable = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand and source registers. src is captured with start so later
  // writes to IX/IY by other units cannot leak into the stored value.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      r_nn  <= '0;
      r_src <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_src <= sel_iy ? iy : ix;
      end
      if (r_state == ST_RD_LO && mem_ack) begin
        r_nn[DATA_W-1:0] <= mem_rdata;
      end
      if (r_state == ST_RD_HI && mem_ack) begin
        r_nn[ADDR_W-1:DATA_W] <= mem_rdata;
      end
    end
  end

`ifdef LD_NN_IXIY_MEMPTR_EN
  logic [ADDR_W-1:0] r_memptr;

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      r_memptr <= '0;
    end else if (r_state == ST_WR_HI && mem_ack) begin
      r_memptr <= w_nn_inc;
    end
  end

  assign memptr = r_memptr;
`endif

endmodule

// File: tb/tb_ld_nn_ixiy_store_seq.sv
// ---------------------------------------------------------------------------
// tb_ld_nn_ixiy_store_seq
// Self-checking bench for ld_nn_ixiy_store_seq. A byte-array memory answers
// the DUT's transfers; each instruction is compared against an expected
// record (hand-written table rows, then randomly generated rows built by a
// reference model from the instruction's rules). Hand-written sequences
// cover reset during the high-byte write and acks arriving in IDLE.
// Define LD_NN_IXIY_MEMPTR_EN for both DUT and bench to check memptr.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ld_nn_ixiy_store_seq;

  logic        CLK = 1'b0;
  logic        notRESET = 1'b0;
  logic        start = 1'b0;
  logic        sel_iy = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] ix = '0;
  logic [15:0] iy = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        pc_inc;
  logic        busy;
  logic [3:0]  xpt;
  logic        set_cm1;
  logic        reset_itable;
`ifdef LD_NN_IXIY_MEMPTR_EN
  logic [15:0] memptr;
`endif

  ld_nn_ixiy_store_seq dut (
    .CLK          (CLK),
    .notRESET     (notRESET),
    .start        (start),
    .sel_iy       (sel_iy),
    .pc           (pc),
    .ix           (ix),
    .iy           (iy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .pc_inc       (pc_inc),
    .busy         (busy),
    .xpt          (xpt),
    .set_cm1      (set_cm1),
    .reset_itable (reset_itable)
`ifdef LD_NN_IXIY_MEMPTR_EN
    ,
    .memptr       (memptr)
`endif
  );

  always #5 CLK = ~CLK;

  // One instruction: stimulus plus everything it must produce.
  typedef struct {
    logic        sel;
    logic [15:0] ixv;
    logic [15:0] iyv;
    logic [15:0] pcv;
    logic [15:0] nnv;
    logic [7:0]  waits;   // 2 bits of wait cycles per transfer, transfer 0 in [1:0]
    logic        poke;    // pulse start again while the low byte is written
    int          lat;     // cycles from the start cycle to the set_cm1 cycle, inclusive
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [15:0] wa0;
    logic [15:0] wa1;
    logic [7:0]  wd0;
    logic [7:0]  wd1;
    logic [15:0] mptr;
  } vec_t;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what one store instruction must do, from its rules.
  function automatic vec_t model(input logic sel, input logic [15:0] ixv, input logic [15:0] iyv,
                                 input logic [15:0] pcv, input logic [15:0] nnv,
                                 input logic [7:0] waits, input logic poke);
    vec_t v;
    logic [15:0] src;
    src     = sel ? iyv : ixv;
    v.sel   = sel;  v.ixv = ixv;  v.iyv = iyv;  v.pcv = pcv;  v.nnv = nnv;
    v.waits = waits; v.poke = poke;
    v.lat   = 2;                           // start cycle + FIN cycle
    for (int k = 0; k < 4; k++) v.lat += int'(waits[2*k +: 2]) + 1;
    v.rd0   = pcv;
    v.rd1   = pcv + 16'd1;
    v.wa0   = nnv;
    v.wa1   = nnv + 16'd1;
    v.wd0   = src[7:0];
    v.wd1   = src[15:8];
    v.mptr  = nnv + 16'd1;
    return v;
  endfunction

  task automatic run_instr(input vec_t v, input string tag);
    logic [15:0] exp_a  [4];
    logic        exp_we [4];
    logic [7:0]  exp_wd [4];
    logic [15:0] obs_a  [4];
    logic        obs_we [4];
    logic [7:0]  obs_wd [4];
    logic [15:0] pcr, snap_a;
    logic        snap_we, poked, done;
    logic [7:0]  snap_wd;
    int cyc, nx, wcnt, inc_n, stab_err, gap_err, itab_err, lat;

    exp_a[0] = v.rd0; exp_a[1] = v.rd1; exp_a[2] = v.wa0; exp_a[3] = v.wa1;
    exp_we[0] = 1'b0; exp_we[1] = 1'b0; exp_we[2] = 1'b1; exp_we[3] = 1'b1;
    exp_wd[0] = 8'h00; exp_wd[1] = 8'h00; exp_wd[2] = v.wd0; exp_wd[3] = v.wd1;
    for (int k = 0; k < 4; k++) begin obs_a[k] = '0; obs_we[k] = 1'b0; obs_wd[k] = '0; end
    mem[v.pcv]         = v.nnv[7:0];
    mem[v.pcv + 16'd1] = v.nnv[15:8];

    @(negedge CLK);
    start = 1'b1; sel_iy = v.sel; ix = v.ixv; iy = v.iyv; pc = v.pcv; mem_ack = 1'b0;
    pcr = v.pcv; cyc = 1; nx = 0; wcnt = 0; inc_n = 0; stab_err = 0; gap_err = 0;
    itab_err = 0; lat = 0; poked = 1'b0; done = 1'b0;
    snap_a = '0; snap_we = 1'b0; snap_wd = '0;

    while (!done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      start = 1'b0; sel_iy = ~v.sel; ix = ~v.ixv; iy = ~v.iyv;   // must not matter any more
      pc = pcr; mem_ack = 1'b0;
      #1;
      if (v.poke && !poked && mem_req && mem_we && xpt == 4'd3) begin
        start = 1'b1; poked = 1'b1;
      end
      if (mem_req && nx < 4) begin
        if (wcnt == 0) begin
          snap_a = mem_addr; snap_we = mem_we; snap_wd = mem_wdata;
        end else if (mem_addr !== snap_a || mem_we !== snap_we ||
                     (snap_we && mem_wdata !== snap_wd)) begin
          stab_err++;
        end
        if (wcnt == int'(v.waits[2*nx +: 2])) begin
          mem_ack = 1'b1;
          obs_a[nx] = mem_addr; obs_we[nx] = mem_we; obs_wd[nx] = mem_we ? mem_wdata : 8'h00;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          nx++; wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!set_cm1) begin
        gap_err++;
      end
      #1;
      if (pc_inc) begin inc_n++; pcr = pcr + 16'd1; end
      if (reset_itable !== set_cm1) itab_err++;
      if (set_cm1) begin done = 1'b1; lat = cyc; end
    end
    mem_ack = 1'b0;
    chk({tag, " timeout"}, {31'd0, done}, 32'd1);

    @(negedge CLK);
    start = 1'b0;
    #1;
    chk({tag, " cm1_one_cycle"}, {31'd0, set_cm1}, 32'd0);
    chk({tag, " idle_after"}, {27'd0, busy, xpt}, 32'd0);

    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " n_xfer"}, nx, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s xfer%0d_addr", tag, k), {16'd0, obs_a[k]}, {16'd0, exp_a[k]});
      chk($sformatf("%s xfer%0d_we", tag, k), {31'd0, obs_we[k]}, {31'd0, exp_we[k]});
      if (exp_we[k])
        chk($sformatf("%s xfer%0d_wdata", tag, k), {24'd0, obs_wd[k]}, {24'd0, exp_wd[k]});
    end
    chk({tag, " pc_inc_count"}, inc_n, 2);
    chk({tag, " hold_during_wait"}, stab_err, 0);
    chk({tag, " req_gap"}, gap_err, 0);
    chk({tag, " itable_with_cm1"}, itab_err, 0);
    chk({tag, " mem_lo"}, {24'd0, mem[v.wa0]}, {24'd0, v.wd0});
    chk({tag, " mem_hi"}, {24'd0, mem[v.wa1]}, {24'd0, v.wd1});
`ifdef LD_NN_IXIY_MEMPTR_EN
    chk({tag, " memptr"}, {16'd0, memptr}, {16'd0, v.mptr});
`endif
    $display("txn %s: sel_iy=%0d nn=%h wrote %h->%h %h->%h latency=%0d (want %0d)",
             tag, v.sel, v.nnv, obs_wd[2], obs_a[2], obs_wd[3], obs_a[3], lat, v.lat);
  endtask

  vec_t tbl [4];

  initial begin
    logic [15:0] pcr;
    logic        got4, cm1_seen;

    tbl[0] = '{1'b0, 16'h1234, 16'h5678, 16'h0100, 16'h8000, 8'h00, 1'b0, 6,
               16'h0100, 16'h0101, 16'h8000, 16'h8001, 8'h34, 8'h12, 16'h8001};
    tbl[1] = '{1'b1, 16'h1111, 16'hBEEF, 16'h0200, 16'h4000, 8'hFF, 1'b1, 18,
               16'h0200, 16'h0201, 16'h4000, 16'h4001, 8'hEF, 8'hBE, 16'h4001};
    tbl[2] = '{1'b0, 16'hA55A, 16'h0000, 16'h1000, 16'hFFFF, 8'h55, 1'b0, 10,
               16'h1000, 16'h1001, 16'hFFFF, 16'h0000, 8'h5A, 8'hA5, 16'h0000};
    tbl[3] = '{1'b1, 16'h0000, 16'h00FF, 16'hFFFF, 16'h1234, 8'hAA, 1'b1, 14,
               16'hFFFF, 16'h0000, 16'h1234, 16'h1235, 8'hFF, 8'h00, 16'h1235};

    // Reset state.
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_ctrl", {26'd0, mem_req, mem_we, busy, pc_inc, set_cm1, reset_itable}, 32'd0);
    chk("reset_xpt", {28'd0, xpt}, 32'd0);
    chk("reset_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
`ifdef LD_NN_IXIY_MEMPTR_EN
    chk("reset_memptr", {16'd0, memptr}, 32'd0);
`endif
    @(negedge CLK);
    notRESET = 1'b1;

    // Stray acks in IDLE.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      mem_ack = 1'b1;
      #1;
      chk($sformatf("stray_ack%0d", c), {28'd0, mem_req, pc_inc, busy, set_cm1}, 32'd0);
      chk($sformatf("stray_ack%0d_xpt", c), {28'd0, xpt}, 32'd0);
    end
    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_after", {27'd0, busy, xpt}, 32'd0);

    // Directed table.
    for (int i = 0; i < 4; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));

    // Randomized instructions against the reference model.
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      logic [15:0] nnr;
      nnr = (i % 6 == 0) ? 16'hFFFF : 16'($urandom);
      v = model(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), nnr,
                8'($urandom), 1'($urandom));
      run_instr(v, $sformatf("rnd%0d", i));
    end

    // Reset while the high byte is being written.
    @(negedge CLK);
    start = 1'b1; sel_iy = 1'b0; ix = 16'hCAFE; pc = 16'h0300;
    mem[16'h0300] = 8'h00; mem[16'h0301] = 8'h50;
    pcr = 16'h0300; got4 = 1'b0; cm1_seen = 1'b0;
    for (int c = 0; c < 20 && !got4; c++) begin
      @(negedge CLK);
      start = 1'b0; pc = pcr; mem_ack = 1'b0;
      #1;
      if (xpt == 4'd4) got4 = 1'b1;
      else if (mem_req) begin
        mem_ack = 1'b1;
        if (!mem_we) mem_rdata = mem[mem_addr];
      end
      #1;
      if (pc_inc) pcr = pcr + 16'd1;
      if (set_cm1) cm1_seen = 1'b1;
    end
    chk("rst_reach_wr_hi", {31'd0, got4}, 32'd1);
    chk("rst_wr_hi_addr", {16'd0, mem_addr}, 32'h00005001);
    #1 notRESET = 1'b0;           // mid-cycle, well away from any clock edge
    #1;
    chk("rst_async_ctrl", {26'd0, mem_req, mem_we, busy, pc_inc, set_cm1, reset_itable}, 32'd0);
    chk("rst_async_xpt", {28'd0, xpt}, 32'd0);
`ifdef LD_NN_IXIY_MEMPTR_EN
    chk("rst_async_memptr", {16'd0, memptr}, 32'd0);
`endif
    @(negedge CLK);
    notRESET = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      #1;
      if (set_cm1) cm1_seen = 1'b1;
      if (c == 5) chk("rst_stays_idle", {27'd0, busy, xpt}, 32'd0);
    end
    chk("rst_no_cm1", {31'd0, cm1_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_nn_ixiy_store_seq.md
Name: ld_nn_ixiy_store_seq

Overview:
- Multi-cycle execution sequencer for the store direction of the indexed 16-bit load: LD (nn),IX / LD (nn),IY (DD/FD 22).
- Sits after the prefix/opcode decoder, which pulses `start`. It then owns the memory port until the instruction completes.
- Fetches the nn operand (low byte, then high byte) and writes the selected index register to nn (low byte) and nn+1 (high byte).
- On completion it hands control back to the M1 fetch.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width; the block is defined only for 8.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- notRESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the opcode decoder; accepted only in IDLE.
- sel_iy  in  1  sampled with start: 0 = IX, 1 = IY.
- pc  in  16  current PC, used for operand fetch addresses.
- ix  in  16  IX register value.
- iy  in  16  IY register value.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  16  transfer address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid when mem_ack=1.
- mem_ack  in  1  transfer complete.
- pc_inc  out  1  one-cycle pulse requesting PC+1.
- busy  out  1  high in any state except IDLE.
- xpt  out  4  current step number, for the shared step decoders.
- set_cm1  out  1  one-cycle pulse: begin next M1.
- reset_itable  out  1  one-cycle pulse, coincident with set_cm1.

Behaviour:
- States and xpt encodings: IDLE(0), RD_LO(1), RD_HI(2), WR_LO(3), WR_HI(4), FIN(5).
- Reset: state IDLE. All outputs are 0. The nn register and source-data register are cleared to 0.
- IDLE:
  - start=1 → latch src = sel_iy ? iy : ix (16 bits).
  - Next state RD_LO.
  - start=0 → remain in IDLE.
- RD_LO:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On the cycle where mem_req && mem_ack: nn[7:0] ← mem_rdata, pc_inc=1 that same cycle, next state RD_HI.
- RD_HI:
  - Same as RD_LO (mem_addr=pc, which has already advanced).
  - On ack: nn[15:8] ← mem_rdata, pc_inc=1, next state WR_LO.
- WR_LO:
  - mem_req=1, mem_we=1, mem_addr=nn, mem_wdata=src[7:0].
  - On ack: next state WR_HI.
- WR_HI:
  - mem_addr = nn+1, computed modulo 2^16, so nn=0xFFFF wraps to 0x0000. mem_wdata=src[15:8].
  - On ack: next state FIN.
- FIN: set_cm1=1 and reset_itable=1 for exactly one cycle, then IDLE.
- Handshake:
  - mem_req and all mem_* outputs are held stable until ack.
  - A mem_ack received while mem_req=0 is ignored.
  - Ack may arrive in the first cycle of a state. Minimum latency start→set_cm1 is 6 cycles (1 per state, FIN included).
  - mem_req drops for one cycle between transfers only if the state changes to FIN; back-to-back transfers keep mem_req high and only address/we change.
- Simultaneous events:
  - start while busy is ignored; no queueing.
  - Changes to ix/iy after start have no effect, because src is latched.
- pc_inc fires only on read acks. It never fires on writes.
- notRESET asserted in mid-operation: immediate return to IDLE with all outputs 0. A partially written memory location is not rolled back.

Optional Feature:
- Macro: LD_NN_IXIY_MEMPTR_EN.
- Defined:
  - Adds output memptr[15:0], which resets to 0.
  - Loaded with nn+1 (mod 2^16) on the WR_HI ack. It holds its value otherwise.
  - Matches the Z80 WZ side effect.
- Undefined: port absent. No extra flops.

Decomposition:
- Shared package (e.g. norz_exec_pkg) holds:
  - State enum with the explicit xpt encodings above.
  - Opcode constants PFX_IX=8'hDD, PFX_IY=8'hFD, OP_LD_NN_RR=8'h22.
  - ADDR_W/DATA_W defaults.
- One natural sub-module: inc16 (16-bit +1 with wrap). It is shared by the nn+1 generation and memptr.
- The FSM itself stays flat.

Test Plan:
- IX store, zero-wait:
  - Stimulus: ix=16'h1234, pc=16'h0100; memory returns 8'h00 then 8'h80; mem_ack held 1.
  - Required: reads at 0x0100 and 0x0101; writes 0x34→0x8000 and 0x12→0x8001; pc_inc pulses twice; set_cm1 at cycle 6 after start.
- IY select with waits:
  - Stimulus: sel_iy=1, iy=16'hBEEF; 3 wait cycles on every transfer.
  - Required: mem_* outputs stable during waits; writes 0xEF then 0xBE; 18-cycle total latency.
- Address wrap:
  - Stimulus: nn=16'hFFFF.
  - Required: low byte written to 0xFFFF, high byte to 0x0000; memptr=16'h0000 with the feature enabled.
- Ignored start and latched source:
  - Stimulus: start pulsed during WR_LO, and ix changed after start.
  - Required: no restart; written data equals the ix value at start.
- Reset mid-WR_HI:
  - Stimulus: notRESET low during WR_HI.
  - Required: asynchronous return of mem_req=0, busy=0, xpt=0; set_cm1 never asserted.
- Stray ack:
  - Stimulus: mem_ack=1 in IDLE.
  - Required: no state change, pc_inc stays 0.
